// File: rtl/rr_tdm_mac.sv
// Round-robin time-multiplexed multiplier: per-channel input FIFOs feed one shared
// 3-stage multiply pipeline, each channel scaled by its own running coefficient counter.
module rr_tdm_mac #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned COEF_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH*DATA_W-1:0]  in_data,
    input  logic [NUM_CH-1:0]         in_valid,
    output logic [NUM_CH-1:0]         in_ready,
    input  logic [NUM_CH-1:0]         ch_enable,
    output logic [DATA_W+COEF_W-1:0]  out_data,
    output logic [$clog2(NUM_CH)-1:0] out_ch,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int unsigned CH_W   = $clog2(NUM_CH);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned PROD_W = DATA_W + COEF_W;

    logic [DATA_W-1:0] mem_q    [NUM_CH][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_q    [NUM_CH];
    logic [CNT_W-1:0]  cnt_d    [NUM_CH];
    logic [COEF_W-1:0] coef_q   [NUM_CH];

    logic [NUM_CH-1:0] ready_q;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] elig;
    logic [CH_W-1:0]   last_q;
    logic [CH_W-1:0]   grant_idx;
    logic              grant_vld;
    logic              adv;
    int unsigned       arb_idx;
    logic [DATA_W-1:0] head_data;

    logic              s1_vld_q;
    logic [DATA_W-1:0] s1_data_q;
    logic [COEF_W-1:0] s1_coef_q;
    logic [CH_W-1:0]   s1_ch_q;
    logic              s2_vld_q;
    logic [PROD_W-1:0] s2_prod_q;
    logic [CH_W-1:0]   s2_ch_q;
    logic              s3_vld_q;
    logic [PROD_W-1:0] s3_prod_q;
    logic [CH_W-1:0]   s3_ch_q;

    assign in_ready  = ready_q;
    assign push      = in_valid & ready_q;
    assign adv       = !(s3_vld_q && !out_ready);
    assign head_data = mem_q[grant_idx][rd_ptr_q[grant_idx]];
    assign out_data  = s3_prod_q;
    assign out_ch    = s3_ch_q;
    assign out_valid = s3_vld_q;

    always_comb begin
        elig = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            elig[k] = (cnt_q[k] != '0) && ch_enable[k];
        end
    end

    // Rotating-priority search starting just past the last granted channel.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        arb_idx   = 0;
        pop       = '0;
        if (adv) begin
            for (int unsigned i = 1; i <= NUM_CH; i++) begin
                arb_idx = 32'(last_q) + i;
                if (arb_idx >= NUM_CH) begin
                    arb_idx = arb_idx - NUM_CH;
                end
                if (!grant_vld && elig[CH_W'(arb_idx)]) begin
                    grant_vld = 1'b1;
                    grant_idx = CH_W'(arb_idx);
                end
            end
        end
        if (grant_vld) begin
            pop[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        for (int k = 0; k < int'(NUM_CH); k++) begin
            cnt_d[k] = cnt_q[k];
            if (push[k] && !pop[k]) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end else if (!push[k] && pop[k]) begin
                cnt_d[k] = cnt_q[k] - CNT_W'(1);
            end
        end
    end

    // FIFO pointers/occupancy; ready is a registered image of not-full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q <= '0;
            for (int k = 0; k < int'(NUM_CH); k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < int'(NUM_CH); k++) begin
                if (push[k]) begin
                    wr_ptr_q[k] <= wr_ptr_q[k] + PTR_W'(1);
                end
                if (pop[k]) begin
                    rd_ptr_q[k] <= rd_ptr_q[k] + PTR_W'(1);
                end
                cnt_q[k]   <= cnt_d[k];
                ready_q[k] <= (cnt_d[k] != CNT_W'(FIFO_DEPTH));
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(NUM_CH); k++) begin
            if (push[k]) begin
                mem_q[k][wr_ptr_q[k]] <= in_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Even channels ramp up from zero, odd channels ramp down from all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= CH_W'(NUM_CH - 1);
            for (int k = 0; k < int'(NUM_CH); k++) begin
                coef_q[k] <= (k % 2 != 0) ? {COEF_W{1'b1}} : '0;
            end
        end else if (grant_vld) begin
            last_q <= grant_idx;
            if (grant_idx[0]) begin
                coef_q[grant_idx] <= coef_q[grant_idx] - COEF_W'(1);
            end else begin
                coef_q[grant_idx] <= coef_q[grant_idx] + COEF_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
            s1_coef_q <= '0;
            s1_ch_q   <= '0;
            s2_vld_q  <= 1'b0;
            s2_prod_q <= '0;
            s2_ch_q   <= '0;
            s3_vld_q  <= 1'b0;
            s3_prod_q <= '0;
            s3_ch_q   <= '0;
        end else if (adv) begin
            s1_vld_q  <= grant_vld;
            s1_data_q <= head_data;
            s1_coef_q <= coef_q[grant_idx];
            s1_ch_q   <= grant_idx;
            s2_vld_q  <= s1_vld_q;
            s2_prod_q <= PROD_W'(s1_data_q) * PROD_W'(s1_coef_q);
            s2_ch_q   <= s1_ch_q;
            s3_vld_q  <= s2_vld_q;
            s3_prod_q <= s2_prod_q;
            s3_ch_q   <= s2_ch_q;
        end
    end

endmodule

// File: tb/tb_rr_tdm_mac.sv
// Directed bench for rr_tdm_mac: latency, fairness, backpressure, coefficient wrap,
// enable masking and mid-burst reset, checked against hand values and a coefficient model.
module tb_rr_tdm_mac;

    localparam int DATA_W = 8;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [3:0]  ch_enable;
    logic [15:0] out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          got_ch[$];
    logic [15:0] got_data[$];
    int          got_cyc[$];
    int          exp_ch[$];
    logic [15:0] exp_data[$];
    logic [7:0]  coef_m [4];
    int          mask_seq [16];
    int          occ [4];

    rr_tdm_mac dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ch_enable (ch_enable),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst && out_valid && out_ready) begin
            got_ch.push_back(int'(out_ch));
            got_data.push_back(out_data);
            got_cyc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] gd(input int i);
        return (i < got_data.size()) ? got_data[i] : 16'hxxxx;
    endfunction

    function automatic int gc(input int i);
        return (i < got_ch.size()) ? got_ch[i] : -1;
    endfunction

    task automatic clear_q();
        got_ch.delete();
        got_data.delete();
        got_cyc.delete();
        exp_ch.delete();
        exp_data.delete();
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            coef_m[k] = (k % 2 != 0) ? 8'hFF : 8'h00;
        end
        clear_q();
    endtask

    task automatic exp_add(input int ch, input logic [7:0] d);
        exp_ch.push_back(ch);
        exp_data.push_back(16'(d) * 16'(coef_m[ch]));
        if (ch % 2 != 0) coef_m[ch] = coef_m[ch] - 8'd1;
        else             coef_m[ch] = coef_m[ch] + 8'd1;
    endtask

    task automatic do_reset();
        in_valid = '0;
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        model_reset();
    endtask

    task automatic push1(input int ch, input logic [7:0] d);
        int b;
        b = 0;
        while (!in_ready[ch] && b < 20) begin
            step();
            b++;
        end
        if (b >= 20) chk("push_timeout", 32'(b), 32'(0));
        in_valid[ch] = 1'b1;
        in_data[ch*DATA_W +: DATA_W] = d;
        step();
        in_valid[ch] = 1'b0;
    endtask

    task automatic wait_got(input string tag, input int n, input int budget);
        int b;
        b = 0;
        while (got_ch.size() < n && b < budget) begin
            step();
            b++;
        end
        repeat (6) step();
        chk({tag, "_count"}, 32'(got_ch.size()), 32'(n));
    endtask

    task automatic cmp_stream(input string tag);
        for (int i = 0; i < exp_ch.size(); i++) begin
            chk({tag, "_ch"}, 32'(gc(i)), 32'(exp_ch[i]));
            chk({tag, "_data"}, 32'(gd(i)), 32'(exp_data[i]));
        end
    endtask

    initial begin
        int gaps;
        mask_seq = '{0, 1, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 2};
        rst       = 1'b0;
        in_data   = '0;
        in_valid  = '0;
        ch_enable = 4'hF;
        out_ready = 1'b1;
        model_reset();

        // Reset state
        repeat (3) step();
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_out_ch", 32'(out_ch), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        rst = 1'b1;
        step();
        chk("post_rst_in_ready", 32'(in_ready), 32'hF);

        // Single sample latency: pushed in cycle t, visible in cycle t+4
        in_valid[0] = 1'b1;
        in_data[7:0] = 8'd5;
        step();
        in_valid[0] = 1'b0;
        chk("lat_t1", 32'(out_valid), 32'(0));
        step();
        chk("lat_t2", 32'(out_valid), 32'(0));
        step();
        chk("lat_t3", 32'(out_valid), 32'(0));
        step();
        chk("lat_t4_valid", 32'(out_valid), 32'(1));
        chk("lat_t4_data", 32'(out_data), 32'(0));
        chk("lat_t4_ch", 32'(out_ch), 32'(0));
        exp_add(0, 8'd5);
        exp_add(0, 8'd5);
        push1(0, 8'd5);
        wait_got("single", 2, 50);
        cmp_stream("single");
        chk("single_second", 32'(gd(1)), 32'd5);

        // Fairness with all FIFOs preloaded
        do_reset();
        ch_enable = 4'h0;
        for (int j = 0; j < 4; j++) begin
            in_valid = 4'hF;
            for (int k = 0; k < 4; k++) in_data[k*DATA_W +: DATA_W] = 8'(16*k + j + 1);
            step();
        end
        in_valid = 4'h0;
        chk("preload_full", 32'(in_ready), 32'h0);
        for (int j = 0; j < 4; j++)
            for (int k = 0; k < 4; k++) exp_add(k, 8'(16*k + j + 1));
        ch_enable = 4'hF;
        wait_got("fair", 16, 100);
        cmp_stream("fair");
        chk("fair_ch1_first", 32'(gd(1)), 32'd4335);
        gaps = 0;
        for (int i = 1; i < got_cyc.size(); i++)
            if (got_cyc[i] != got_cyc[i-1] + 1) gaps++;
        chk("fair_bubbles", 32'(gaps), 32'(0));

        // Backpressure: ten stalled cycles while ch0 keeps offering data
        clear_q();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid[0] = 1'b1;
            in_data[7:0] = 8'(16 + i);
            chk("bp_in_ready", 32'(in_ready[0]), 32'(i < 7));
            if (i < 7) exp_add(0, 8'(16 + i));
            step();
            if (i + 1 >= 4) begin
                chk("bp_valid", 32'(out_valid), 32'(1));
                chk("bp_hold_data", 32'(out_data), 32'd64);
                chk("bp_hold_ch", 32'(out_ch), 32'(0));
            end
        end
        in_valid = 4'h0;
        out_ready = 1'b1;
        wait_got("bp", 7, 100);
        cmp_stream("bp");
        chk("bp_ready_back", 32'(in_ready), 32'hF);

        // Odd-channel coefficient wrap
        do_reset();
        for (int i = 0; i < 257; i++) begin
            exp_add(1, 8'd1);
            push1(1, 8'd1);
        end
        wait_got("wrap", 257, 400);
        cmp_stream("wrap");
        chk("wrap_first", 32'(gd(0)), 32'd255);
        chk("wrap_zero", 32'(gd(255)), 32'd0);
        chk("wrap_last", 32'(gd(256)), 32'd255);

        // Enable masking, then ch2 re-enabled after four grants
        do_reset();
        ch_enable = 4'h0;
        for (int j = 0; j < 4; j++) begin
            in_valid = 4'hF;
            for (int k = 0; k < 4; k++) in_data[k*DATA_W +: DATA_W] = 8'(8'h40 + 4*k + j);
            step();
        end
        in_valid = 4'h0;
        ch_enable = 4'b1011;
        repeat (3) step();
        chk("mask_ready", 32'(in_ready), 32'b1011);
        step();
        ch_enable = 4'hF;
        for (int k = 0; k < 4; k++) occ[k] = 0;
        for (int i = 0; i < 16; i++) begin
            exp_add(mask_seq[i], 8'(8'h40 + 4*mask_seq[i] + occ[mask_seq[i]]));
            occ[mask_seq[i]]++;
        end
        wait_got("mask", 16, 100);
        cmp_stream("mask");

        // Reset in the middle of full traffic
        clear_q();
        ch_enable = 4'hF;
        out_ready = 1'b1;
        in_data = 32'h0403_0201;
        in_valid = 4'hF;
        repeat (8) step();
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'(0));
        chk("midrst_out_data", 32'(out_data), 32'(0));
        chk("midrst_out_ch", 32'(out_ch), 32'(0));
        chk("midrst_in_ready", 32'(in_ready), 32'h0);
        in_valid = 4'h0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        step();
        chk("midrst_ready_back", 32'(in_ready), 32'hF);
        exp_add(0, 8'd7);
        push1(0, 8'd7);
        wait_got("midrst", 1, 50);
        cmp_stream("midrst");
        chk("midrst_first", 32'(gd(0)), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
